// File: rtl/ring_counter_pkg.sv
// ----------------------------------------------------------------------------
// ring_counter_pkg
//
// Shared definitions for the multi-mode shift-pattern counter:
//   - mode_t    : encodings of the 2-bit mode input
//   - bdir_t    : travel direction of the hot bit in bounce mode
//   - popcount  : number of set bits in the low w bits of a vector
//   - is_onehot : exactly one bit set in the low w bits
//   - is_thermo : thermometer pattern (ones anchored at LSB or MSB, or zero)
//
// The helpers work on a vector of MAX_WIDTH bits plus an explicit width so
// that one set of functions serves every WIDTH the counter is built with.
// Callers zero-extend their pattern into MAX_WIDTH bits.
// ----------------------------------------------------------------------------
package ring_counter_pkg;

    // Widest pattern the helper functions can inspect.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    typedef enum logic {
        BDIR_UP   = 1'b0,
        BDIR_DOWN = 1'b1
    } bdir_t;

    // Count of ones in bits [w-1:0] of v.
    function automatic logic [7:0] popcount(input logic [MAX_WIDTH-1:0] v,
                                            input int w);
        logic [7:0] count;
        count = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((i < w) && v[i]) begin
                count = count + 8'd1;
            end
        end
        return count;
    endfunction

    // True when exactly one of bits [w-1:0] is set.
    function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] v,
                                       input int w);
        return (popcount(v, w) == 8'd1);
    endfunction

    // A thermometer code has at most one 0/1 boundary between adjacent bits:
    // 0..011..1 (anchored at the LSB), 1..100..0 (anchored at the MSB), all
    // zeros or all ones. Counting boundaries covers every case at once.
    function automatic logic is_thermo(input logic [MAX_WIDTH-1:0] v,
                                       input int w);
        int edges;
        edges = 0;
        for (int i = 1; i < MAX_WIDTH; i++) begin
            if ((i < w) && (v[i] != v[i-1])) begin
                edges = edges + 1;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/ring_counter_check.sv
// ----------------------------------------------------------------------------
// ring_counter_check
//
// Purely combinational legality checker and position decoder for one
// pattern under one mode. The top level uses one copy on the live pattern
// and a second copy on the pattern offered for loading.
//
// Parameters:
//   WIDTH  pattern width (>= 3, <= MAX_WIDTH)
//   PW     width of pos, $clog2(2*WIDTH)
// Ports:
//   T      in   WIDTH  pattern to inspect
//   mode   in   2      mode the pattern is judged against
//   legal  out  1      pattern is a legal state of that mode
//   pos    out  PW     decoded position, 0 while the pattern is illegal
//
// Ring, bounce and hold all treat a one-hot pattern as legal and report the
// index of the hot bit. Johnson accepts any thermometer code and numbers the
// 2*WIDTH states so that 0..01 is position 0 and 0..0 is the last position.
// ----------------------------------------------------------------------------
module ring_counter_check
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] T,
    input  logic [1:0]       mode,
    output logic             legal,
    output logic [PW-1:0]    pos
);

    mode_t                mode_e;
    logic [MAX_WIDTH-1:0] ext;
    logic                 onehot;
    logic                 thermo;
    logic [PW-1:0]        hot_idx;
    logic [PW-1:0]        john_idx;

    assign mode_e = mode_t'(mode);
    assign ext    = MAX_WIDTH'(T);
    assign onehot = is_onehot(ext, WIDTH);
    assign thermo = is_thermo(ext, WIDTH);

    // Index of the hot bit. Only meaningful when the pattern is one-hot, so
    // letting the highest set bit win is harmless for illegal patterns.
    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (T[i]) begin
                hot_idx = PW'(i);
            end
        end
    end

    // Johnson numbering: while the MSB is clear the ones are still filling
    // from the LSB, so the position is popcount-1 (wrapping 0..0 to the last
    // state). Once the MSB is set the zeros are filling from the LSB and the
    // position counts down from 2W-1 as the ones drain away.
    always_comb begin
        int pc;
        int idx;
        pc  = int'(popcount(ext, WIDTH));
        idx = 0;
        if (!T[WIDTH-1]) begin
            idx = (pc == 0) ? (2*WIDTH - 1) : (pc - 1);
        end else begin
            idx = 2*WIDTH - 1 - pc;
        end
        john_idx = PW'(idx);
    end

    // Select legality and position for the requested mode; position is
    // forced to zero whenever the pattern does not belong to the mode.
    always_comb begin
        legal = 1'b0;
        pos   = '0;
        case (mode_e)
            MODE_JOHNSON: begin
                legal = thermo;
                if (thermo) begin
                    pos = john_idx;
                end
            end
            default: begin
                legal = onehot;
                if (onehot) begin
                    pos = hot_idx;
                end
            end
        endcase
    end

endmodule

// File: rtl/ring_counter_multi.sv
// ----------------------------------------------------------------------------
// ring_counter_multi
//
// Parametrised multi-mode shift-pattern counter: one-hot ring, Johnson
// (twisted ring) or one-hot bounce, with direction, enable, synchronous
// load and recovery from illegal patterns.
//
// Parameters:
//   WIDTH  pattern width (>= 3)
//   PW     width of pos, derived from WIDTH; do not override
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      step enable
//   dir       in   1      0 shifts toward MSB, 1 toward LSB (not bounce)
//   mode      in   2      00 ring, 01 Johnson, 10 bounce, 11 hold
//   load      in   1      synchronous load strobe (beats en)
//   load_val  in   WIDTH  pattern to load
//   T         out  WIDTH  current pattern
//   pos       out  PW     decoded position of T (combinational)
//   wrap      out  1      pulse when a step lands on position 0
//   err       out  1      pulse when an illegal pattern was replaced
// ----------------------------------------------------------------------------
module ring_counter_multi
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] T,
    output logic [PW-1:0]    pos,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] PAT_ONE = WIDTH'(1);

    mode_t            mode_e;
    bdir_t            bdir;
    bdir_t            bdir_next;
    bdir_t            step_bdir;
    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] step_val;
    logic             wrap_next;
    logic             err_next;
    logic             t_legal;
    logic             load_legal;
    logic [PW-1:0]    load_pos;
    logic             move_down;

    assign mode_e = mode_t'(mode);

    // Legality and position of the live pattern; pos goes straight out.
    ring_counter_check #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_check_t (
        .T     (T),
        .mode  (mode),
        .legal (t_legal),
        .pos   (pos)
    );

    // Legality of the pattern offered for loading. Its decoded position also
    // tells us whether a bounce load lands on the top bit.
    ring_counter_check #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_check_load (
        .T     (load_val),
        .mode  (mode),
        .legal (load_legal),
        .pos   (load_pos)
    );

    // Bounce travel for this step. The stored direction is normally already
    // correct at the ends, but a pattern inherited from another mode can sit
    // on an end bit with the flag pointing outward; reflecting off the end
    // here keeps the hot bit from falling off the pattern.
    always_comb begin
        move_down = 1'b0;
        if (bdir == BDIR_DOWN) begin
            move_down = !T[0];
        end else begin
            move_down = T[WIDTH-1];
        end
    end

    // Candidate pattern and bounce direction if this edge is a legal step.
    // In bounce mode the flag flips on arrival at an end bit, so it always
    // names the direction of the next move.
    always_comb begin
        step_val  = T;
        step_bdir = bdir;
        case (mode_e)
            MODE_RING: begin
                if (dir) begin
                    step_val = {T[0], T[WIDTH-1:1]};
                end else begin
                    step_val = {T[WIDTH-2:0], T[WIDTH-1]};
                end
            end
            MODE_JOHNSON: begin
                if (dir) begin
                    step_val = {~T[0], T[WIDTH-1:1]};
                end else begin
                    step_val = {T[WIDTH-2:0], ~T[WIDTH-1]};
                end
            end
            MODE_BOUNCE: begin
                if (move_down) begin
                    step_val = T >> 1;
                end else begin
                    step_val = T << 1;
                end
                if (step_val[WIDTH-1]) begin
                    step_bdir = BDIR_DOWN;
                end else if (step_val[0]) begin
                    step_bdir = BDIR_UP;
                end else begin
                    step_bdir = move_down ? BDIR_DOWN : BDIR_UP;
                end
            end
            default: begin
                step_val  = T;
                step_bdir = bdir;
            end
        endcase
    end

    // Per-edge decision: load beats step beats hold, and hold mode freezes
    // everything including loads. Any illegal pattern, whether offered by a
    // load or found in T at a step, is replaced by the reset pattern with an
    // err pulse. wrap only ever comes from a legal step landing on 0..01,
    // which is position 0 in every mode, so it can never coincide with err.
    always_comb begin
        t_next    = T;
        bdir_next = bdir;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (mode_e != MODE_HOLD) begin
            if (load) begin
                if (load_legal) begin
                    t_next = load_val;
                    if (mode_e == MODE_BOUNCE) begin
                        bdir_next = (load_pos == PW'(WIDTH-1)) ? BDIR_DOWN
                                                                : BDIR_UP;
                    end
                end else begin
                    t_next    = PAT_ONE;
                    bdir_next = BDIR_UP;
                    err_next  = 1'b1;
                end
            end else if (en) begin
                if (t_legal) begin
                    t_next    = step_val;
                    bdir_next = step_bdir;
                    wrap_next = (step_val == PAT_ONE);
                end else begin
                    t_next    = PAT_ONE;
                    bdir_next = BDIR_UP;
                    err_next  = 1'b1;
                end
            end
        end
    end

    // Pattern, bounce direction and the two status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            T    <= PAT_ONE;
            bdir <= BDIR_UP;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            T    <= t_next;
            bdir <= bdir_next;
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

endmodule
